gray2bin_arbiter: RTL and testbench
===================================

// Module: gray2bin_arbiter
//
// PURPOSE
//   Shares one registered Gray-to-binary conversion unit among N_REQ requesters.
//   - Accepts one Gray word per grant, in round-robin order.
//   - Converts the word and presents the binary result with the requester ID.
//   - Holds the result under a valid/ready handshake.
//   - Sits between Gray-coded sources (position encoders, CDC pointers) and binary consumers.
//
// PARAMETERS
//   N_REQ  4  number of requesters (>=2)
//   WIDTH  4  Gray/binary word width (>=2)
//   IDW    2  requester ID width, equal to $clog2(N_REQ)
//
// PORTS
//   clk        in   1            rising-edge clock
//   rst        in   1            synchronous reset, active-high
//   req_valid  in   N_REQ        per-requester request valid
//   req_gray   in   N_REQ*WIDTH  Gray words; requester i uses [i*WIDTH +: WIDTH]
//   req_ready  out  N_REQ        one-hot accept strobe; at most one bit high
//   out_valid  out  1            result valid
//   out_bin    out  WIDTH        converted binary word
//   out_id     out  IDW          index of the requester that owns out_bin
//   out_ready  in   1            consumer accepts the result
//
// BEHAVIOUR
//   Reset values
//   - State = IDLE; out_valid = 0; out_bin = 0; out_id = 0.
//   - req_ready = 0; last-grant pointer = N_REQ-1, so requester 0 has first priority.
//   FSM: IDLE -> CONV -> HOLD -> IDLE
//   - IDLE: if any req_valid is high, grant the first valid requester searching
//     from (ptr+1) mod N_REQ upward with wrap-around.
//     - req_ready[grant] = 1 combinationally in this cycle; this is the transfer.
//     - On the clock edge: latch req_gray slice and grant ID; ptr <= grant; go to CONV.
//     - No valid request: stay in IDLE; req_ready = 0.
//   - CONV: compute bin[WIDTH-1] = g[WIDTH-1] and bin[i] = bin[i+1] ^ g[i]
//     (XOR prefix from the MSB).
//     - Register the result into out_bin and out_id; go to HOLD.
//     - req_ready = 0.
//   - HOLD: out_valid = 1, with out_bin and out_id stable.
//     - On out_valid & out_ready: go to IDLE; out_valid drops the next cycle.
//     - req_ready = 0 throughout.
//   Latency and throughput
//   - Accept in cycle T gives out_valid high from T+2.
//   - With out_ready held high, the minimum accept-to-accept spacing is 3 cycles.
//   Requester rules
//   - A requester whose req_valid drops before it is granted is simply skipped.
//   - req_gray is sampled only in the accept cycle.
//   Boundary conditions
//   - All requesters valid continuously: grants go 0,1,2,3,0,...; no starvation.
//   - Single requester valid: it is re-granted every pass regardless of ptr.
//   - out_ready high before out_valid is ignored; no transfer occurs outside HOLD.
//   - Pointer wrap: ptr = N_REQ-1 searches from 0.
//   - rst mid-operation: the in-flight word is discarded, all state returns to
//     reset values, and out_valid is 0 the cycle after rst.
//
// TESTING
//   1. rst then idle: all req_valid=0 for 10 cycles
//      -> req_ready=0, out_valid=0, out_bin=0.
//   2. Single request: req_valid=4'b0001, req_gray[3:0]=4'b1011
//      -> req_ready=4'b0001 in T; out_valid at T+2; out_bin=4'b1101; out_id=0.
//   3. Exhaustive conversion: cycle all 16 Gray codes through requester 2
//      -> out_bin equals the reference XOR-prefix value for every code; out_id=2.
//   4. Fairness: req_valid=4'b1111 held, out_ready=1
//      -> grant order 0,1,2,3,0,1; accepts every 3 cycles.
//   5. Backpressure: out_ready=0 for 5 cycles in HOLD
//      -> out_valid/out_bin/out_id stable; req_ready=0; a new grant occurs only
//         after the handshake.
//   6. rst asserted in CONV with gray=4'b1111
//      -> next cycle out_valid=0 and state IDLE; the following request is served
//         from requester 0.

Source files
------------

// File: rtl/gray2bin_arbiter.sv
// Round-robin arbiter feeding one shared, registered Gray-to-binary converter.
// One word is in flight at a time: accept (IDLE), convert (CONV), present (HOLD).
module gray2bin_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_gray,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_bin,
  output logic [IDW-1:0]           out_id,
  input  logic                     out_ready
);

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] out_bin_q, out_bin_d;
  logic [IDW-1:0]   out_id_q, out_id_d;

  logic             grant_vld;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   cand;

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Search starts one past the last grant, so the previous winner ranks last.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % N_REQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= IDW'(N_REQ-1);
      gray_q    <= '0;
      id_q      <= '0;
      out_bin_q <= '0;
      out_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gray_q    <= gray_d;
      id_q      <= id_d;
      out_bin_q <= out_bin_d;
      out_id_q  <= out_id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = CONV;
      CONV:    state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the granted word on accept; convert it one cycle later.
  always_comb begin
    ptr_d     = ptr_q;
    gray_d    = gray_q;
    id_d      = id_q;
    out_bin_d = out_bin_q;
    out_id_d  = out_id_q;
    if (state_q == IDLE && grant_vld) begin
      ptr_d  = grant_id;
      gray_d = req_gray[grant_id*WIDTH +: WIDTH];
      id_d   = grant_id;
    end
    if (state_q == CONV) begin
      out_bin_d = gray_to_bin(gray_q);
      out_id_d  = id_q;
    end
  end

  always_comb begin
    req_ready = '0;
    out_valid = 1'b0;
    if (state_q == IDLE && grant_vld) req_ready[grant_id] = 1'b1;
    if (state_q == HOLD) out_valid = 1'b1;
  end

  assign out_bin = out_bin_q;
  assign out_id  = out_id_q;

endmodule

// File: tb/tb_gray2bin_arbiter.sv
// Directed bench for gray2bin_arbiter with a cycle model and result scoreboard.
module tb_gray2bin_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*W-1:0] req_gray = '0;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic [W-1:0]  out_bin;
  logic [IW-1:0] out_id;
  logic          out_ready = 1'b0;

  gray2bin_arbiter #(.N_REQ(N), .WIDTH(W), .IDW(IW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_gray(req_gray),
    .req_ready(req_ready), .out_valid(out_valid), .out_bin(out_bin),
    .out_id(out_id), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] bin_ref(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  // Cycle model: 0 = IDLE, 1 = CONV, 2 = HOLD
  int m_state = 0;
  int m_ptr = N-1;
  int m_g;
  logic [N-1:0] m_rr;
  logic [IW-1:0] sb_id[$];
  logic [W-1:0]  sb_bin[$];
  int grant_log[$];
  int acc_cyc[$];

  always @(negedge clk) begin
    if (mon_en) begin
      m_rr = '0;
      m_g = -1;
      if (m_state == 0) begin
        for (int k = 1; k <= N; k++)
          if (m_g < 0 && req_valid[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
        if (m_g >= 0) m_rr[m_g] = 1'b1;
      end
      check("mon_out_valid", {31'd0, out_valid}, {31'd0, m_state == 2});
      check("mon_req_ready", {28'd0, req_ready}, {28'd0, m_rr});
      if (m_state == 2) begin
        check("mon_sb_nonempty", {31'd0, sb_id.size() > 0}, 32'd1);
        if (sb_id.size() > 0) begin
          check("mon_out_id", {30'd0, out_id}, {30'd0, sb_id[0]});
          check("mon_out_bin", {28'd0, out_bin}, {28'd0, sb_bin[0]});
        end
      end
      if (rst) begin
        m_state = 0;
        m_ptr = N-1;
        sb_id.delete();
        sb_bin.delete();
      end else begin
        case (m_state)
          0: if (m_g >= 0) begin
            sb_id.push_back(IW'(m_g));
            sb_bin.push_back(bin_ref(req_gray[m_g*W +: W]));
            grant_log.push_back(m_g);
            acc_cyc.push_back(cyc);
            m_ptr = m_g;
            m_state = 1;
          end
          1: m_state = 2;
          default: if (out_ready) begin
            if (sb_id.size() > 0) begin
              void'(sb_id.pop_front());
              void'(sb_bin.pop_front());
            end
            m_state = 0;
          end
        endcase
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int idx, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[idx]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  bit ok;
  logic [W-1:0] cap_bin;
  logic [IW-1:0] cap_id;
  int hs_cyc;

  initial begin
    // 1: reset, then idle
    tick(2);
    rst = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_req_ready", {28'd0, req_ready}, 32'd0);
      check("idle_out_valid", {31'd0, out_valid}, 32'd0);
      check("idle_out_bin", {28'd0, out_bin}, 32'd0);
      check("idle_out_id", {30'd0, out_id}, 32'd0);
      tick(1);
    end

    // 2: single request, latency
    out_ready = 1'b1;
    req_gray[3:0] = 4'b1011;
    req_valid = 4'b0001;
    @(negedge clk);
    check("single_req_ready_T", {28'd0, req_ready}, 32'h1);
    tick(1);
    req_valid = '0;
    @(negedge clk);
    check("single_valid_T1", {31'd0, out_valid}, 32'd0);
    tick(1);
    @(negedge clk);
    check("single_valid_T2", {31'd0, out_valid}, 32'd1);
    check("single_bin", {28'd0, out_bin}, 32'hD);
    check("single_id", {30'd0, out_id}, 32'd0);
    tick(2);

    // 3: all Gray codes through requester 2
    for (int g = 0; g < 16; g++) begin
      req_gray[2*W +: W] = W'(g);
      req_valid = 4'b0100;
      wait_accept(2, ok);
      check("exh_accept_seen", {31'd0, ok}, 32'd1);
      tick(1);
      req_valid = '0;
      wait_out(ok);
      check("exh_out_seen", {31'd0, ok}, 32'd1);
      check("exh_bin", {28'd0, out_bin}, {28'd0, bin_ref(W'(g))});
      check("exh_id", {30'd0, out_id}, 32'd2);
      tick(1);
    end
    tick(2);

    // 4: fairness from reset pointer
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req_gray = 16'h9C53;
    grant_log.delete();
    acc_cyc.delete();
    req_valid = 4'b1111;
    for (int i = 0; i < 40 && grant_log.size() < 6; i++) @(negedge clk);
    tick(1);
    req_valid = '0;
    check("fair_count", grant_log.size(), 32'd6);
    if (grant_log.size() >= 6) begin
      check("fair_g0", grant_log[0], 32'd0);
      check("fair_g1", grant_log[1], 32'd1);
      check("fair_g2", grant_log[2], 32'd2);
      check("fair_g3", grant_log[3], 32'd3);
      check("fair_g4", grant_log[4], 32'd0);
      check("fair_g5", grant_log[5], 32'd1);
      for (int i = 1; i < 6; i++)
        check("fair_spacing", acc_cyc[i] - acc_cyc[i-1], 32'd3);
    end
    tick(6);

    // 5: backpressure in HOLD
    out_ready = 1'b0;
    req_gray[2*W +: W] = 4'b0110;
    req_valid = 4'b0100;
    wait_accept(2, ok);
    check("bp_accept_seen", {31'd0, ok}, 32'd1);
    tick(1);
    req_valid = '0;
    wait_out(ok);
    check("bp_out_seen", {31'd0, ok}, 32'd1);
    cap_bin = out_bin;
    cap_id = out_id;
    check("bp_bin", {28'd0, cap_bin}, 32'h4);
    tick(1);
    req_valid = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", {31'd0, out_valid}, 32'd1);
      check("bp_bin_stable", {28'd0, out_bin}, {28'd0, cap_bin});
      check("bp_id_stable", {30'd0, out_id}, {30'd0, cap_id});
      check("bp_no_grant", {28'd0, req_ready}, 32'd0);
      tick(1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    hs_cyc = cyc;
    tick(1);
    @(negedge clk);
    check("bp_grant_after_hs", {28'd0, req_ready}, 32'h1);
    check("bp_grant_cycle", cyc - hs_cyc, 32'd1);
    tick(1);
    req_valid = '0;
    tick(5);

    // 6: reset while converting
    req_gray[1*W +: W] = 4'b1111;
    req_valid = 4'b0010;
    wait_accept(1, ok);
    check("rst_accept_seen", {31'd0, ok}, 32'd1);
    tick(1);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("rst_in_conv_valid", {31'd0, out_valid}, 32'd0);
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_after_valid", {31'd0, out_valid}, 32'd0);
    check("rst_after_bin", {28'd0, out_bin}, 32'd0);
    check("rst_after_ready", {28'd0, req_ready}, 32'd0);
    tick(1);
    req_valid = 4'b1111;
    @(negedge clk);
    check("rst_first_grant", {28'd0, req_ready}, 32'h1);
    tick(1);
    req_valid = '0;
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
